// File: rtl/bch_chien_search.sv
// Chien-search error locator for binary BCH over GF(2^M).
// Evaluates sigma(x) at alpha^i for i = 0..N-1, one element per clock.
module bch_chien_search #(
  parameter int         M         = 4,
  parameter int         T         = 3,
  parameter logic [M:0] PRIM_POLY = 5'b10011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [(T+1)*M-1:0]   sigma,
  input  logic [4:0]           degree,
  output logic                 busy,
  output logic                 done,
  output logic [T*M-1:0]       err_pos,
  output logic [T-1:0]         err_valid,
  output logic [(2**M)-2:0]    err_loc_onehot,
  output logic [$clog2(T+1)-1:0] err_count,
  output logic                 fail
);

  localparam int N  = 2**M - 1;
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [M-1:0]  coef_q [T+1];
  logic [M-1:0]  i_q;
  logic [4:0]    deg_q;
  logic [CW-1:0] roots_q;
  logic          ovf_q;
  logic [M-1:0]  s;
  logic [M-1:0]  p;
  logic          root;
  logic          last;

  // Multiply by alpha: shift left, reduce by the primitive polynomial.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    logic [M-1:0] r;
    r = {a[M-2:0], 1'b0};
    if (a[M-1])
      r = r ^ PRIM_POLY[M-1:0];
    return r;
  endfunction

  function automatic logic [M-1:0] mul_pow(
    input logic [M-1:0] a,
    input int           k
  );
    logic [M-1:0] v;
    v = a;
    for (int n = 0; n < T; n++)
      if (n < k)
        v = xtime(v);
    return v;
  endfunction

  always_comb begin
    s = '0;
    for (int j = 0; j <= T; j++)
      s = s ^ coef_q[j];
  end

  assign root = (s == '0);
  assign last = (i_q == M'(N-1));
  assign p    = (i_q == '0) ? '0 : M'(N - int'(i_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SEARCH;
      SEARCH:  if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= T; j++)
        coef_q[j] <= '0;
      i_q            <= '0;
      deg_q          <= '0;
      roots_q        <= '0;
      ovf_q          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_pos        <= '0;
      err_valid      <= '0;
      err_loc_onehot <= '0;
      err_count      <= '0;
      fail           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int j = 0; j <= T; j++)
              coef_q[j] <= (j > int'(degree)) ? '0 : sigma[j*M +: M];
            i_q            <= '0;
            deg_q          <= degree;
            roots_q        <= '0;
            ovf_q          <= 1'b0;
            busy           <= 1'b1;
            err_pos        <= '0;
            err_valid      <= '0;
            err_loc_onehot <= '0;
            err_count      <= '0;
            fail           <= 1'b0;
          end
        end
        SEARCH: begin
          i_q <= i_q + 1'b1;
          for (int j = 0; j <= T; j++)
            coef_q[j] <= mul_pow(coef_q[j], j);
          if (root) begin
            err_loc_onehot[p] <= 1'b1;
            roots_q           <= roots_q + 1'b1;
            if (int'(err_count) < T) begin
              err_pos[int'(err_count)*M +: M] <= p;
              err_valid[err_count]            <= 1'b1;
              err_count                       <= err_count + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          fail <= (int'(deg_q) > T) | ovf_q |
                  (int'(roots_q) != int'(deg_q));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_chien_search.sv
// Scoreboard bench for bch_chien_search (M=4, T=3).
// Expected results come from a Horner-evaluation reference model.
module tb_bch_chien_search;

  localparam int M = 4;
  localparam int T = 3;
  localparam int N = 15;

  typedef struct packed {
    logic [T*M-1:0] pos;
    logic [T-1:0]   valid;
    logic [N-1:0]   oh;
    logic [1:0]     cnt;
    logic           fail;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [(T+1)*M-1:0]   sigma = '0;
  logic [4:0]           degree = '0;
  logic                 busy;
  logic                 done;
  logic [T*M-1:0]       err_pos;
  logic [T-1:0]         err_valid;
  logic [N-1:0]         err_loc_onehot;
  logic [1:0]           err_count;
  logic                 fail;

  exp_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  bch_chien_search #(
    .M(M),
    .T(T),
    .PRIM_POLY(5'b10011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sigma(sigma),
    .degree(degree),
    .busy(busy),
    .done(done),
    .err_pos(err_pos),
    .err_valid(err_valid),
    .err_loc_onehot(err_loc_onehot),
    .err_count(err_count),
    .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b);
    logic [M-1:0] r;
    logic [M-1:0] x;
    r = '0;
    x = a;
    for (int k = 0; k < M; k++) begin
      if (b[k]) r = r ^ x;
      x = x[M-1] ? ({x[M-2:0], 1'b0} ^ 4'h3) : {x[M-2:0], 1'b0};
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [(T+1)*M-1:0] sg,
                                 input logic [4:0] dg);
    exp_t         e;
    logic [M-1:0] x;
    logic [M-1:0] acc;
    logic [M-1:0] c;
    int           roots;
    int           pp;
    logic         ovf;
    e = '0;
    x = 4'h1;
    roots = 0;
    ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc = '0;
      for (int j = T; j >= 0; j--) begin
        c = (j > int'(dg)) ? 4'h0 : sg[j*M +: M];
        acc = gf_mul(acc, x) ^ c;
      end
      if (acc == 4'h0) begin
        pp = (i == 0) ? 0 : N - i;
        e.oh[pp] = 1'b1;
        roots++;
        if (int'(e.cnt) < T) begin
          e.pos[int'(e.cnt)*M +: M] = M'(pp);
          e.valid[e.cnt] = 1'b1;
          e.cnt = e.cnt + 1'b1;
        end else begin
          ovf = 1'b1;
        end
      end
      x = gf_mul(x, 4'h2);
    end
    e.fail = (int'(dg) > T) | ovf | (roots != int'(dg));
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pos"}, 64'(err_pos), 64'd0);
    chk({tag, "_valid"}, 64'(err_valid), 64'd0);
    chk({tag, "_oh"}, 64'(err_loc_onehot), 64'd0);
    chk({tag, "_cnt"}, 64'(err_count), 64'd0);
    chk({tag, "_fail"}, 64'(fail), 64'd0);
  endtask

  task automatic do_vec(input string tag,
                        input logic [(T+1)*M-1:0] sg,
                        input logic [4:0] dg,
                        input bit poke);
    exp_t e;
    int   cyc;
    bit   got;
    @(negedge clk);
    sigma  = sg;
    degree = dg;
    start  = 1'b1;
    q.push_back(model(sg, dg));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy1"}, 64'(busy), 64'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 5) begin
        sigma  = 16'h0bcd;
        degree = 5'd3;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    e = q.pop_front();
    if (!got) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_lat"}, 64'(cyc), 64'd16);
      chk({tag, "_pos"}, 64'(err_pos), 64'(e.pos));
      chk({tag, "_valid"}, 64'(err_valid), 64'(e.valid));
      chk({tag, "_oh"}, 64'(err_loc_onehot), 64'(e.oh));
      chk({tag, "_cnt"}, 64'(err_count), 64'(e.cnt));
      chk({tag, "_fail"}, 64'(fail), 64'(e.fail));
      chk({tag, "_busy0"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, 64'(err_loc_onehot), 64'(e.oh));
    end
  endtask

  initial begin
    int seen;
    #1;
    chk_zero("reset");
    #12;
    @(negedge clk);
    rst = 1'b0;

    do_vec("single", {4'h0, 4'h0, 4'h8, 4'h1}, 5'd1, 1'b0);
    chk("single_p0", 64'(err_pos[3:0]), 64'd3);
    do_vec("double", {4'h0, 4'hB, 4'h2, 4'h1}, 5'd2, 1'b0);
    do_vec("triple", {4'h8, 4'hE, 4'h7, 4'h1}, 5'd3, 1'b0);
    chk("triple_oh", 64'(err_loc_onehot), 64'h7);
    do_vec("dblroot", {4'h0, 4'h2, 4'h0, 4'h1}, 5'd2, 1'b0);
    do_vec("noerr", {4'h0, 4'h0, 4'h0, 4'h1}, 5'd0, 1'b0);
    do_vec("deg4", {4'h8, 4'hE, 4'h7, 4'h1}, 5'd4, 1'b0);
    do_vec("zero", 16'h0000, 5'd0, 1'b0);
    do_vec("poke", {4'h0, 4'hB, 4'h2, 4'h1}, 5'd2, 1'b1);

    @(negedge clk);
    sigma  = {4'h0, 4'hB, 4'h2, 4'h1};
    degree = 5'd2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("midrst_nodone", 64'(seen), 64'd0);

    do_vec("after_rst", {4'h0, 4'h0, 4'h8, 4'h1}, 5'd1, 1'b0);

    for (int r = 0; r < 6; r++)
      do_vec("rand", 16'($urandom), 5'($urandom_range(0, 4)), 1'b0);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
